mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the ARMv8 five-stage pipeline, between the EX/MEM boundary and write-back. It accepts one instruction per handshake and performs aligned loads and stores to the data memory over a variable-latency request/acknowledge port. It sign- or zero-extends load data and registers the result set that the write-back select mux consumes: ALU result, load data and the mux select. Non-memory instructions pass through in one cycle; memory instructions stall the upstream stage until the data memory acknowledges.

## Interface
- No parameters; data width fixed at 64, register index 5 bits.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: an instruction is presented.
- `mem_ready` out 1: stage can accept (high only in IDLE).
- `flush` in 1: discard the presented instruction.
- `ex_alu_result` in 64: ALU result; the effective address for memory ops.
- `ex_store_data` in 64: store operand, right-aligned.
- `ex_mem_read`, `ex_mem_write` in 1 each: load / store.
- `ex_size` in 2: 00 byte, 01 half, 10 word, 11 dword.
- `ex_signed` in 1: sign-extend load.
- `ex_rd` in 5, `ex_reg_write` in 1, `ex_mem_to_reg` in 1: write-back control.
- `dm_req` out 1, `dm_we` out 1, `dm_addr` out 64, `dm_be` out 8, `dm_wdata` out 64: data memory request.
- `dm_ack` in 1, `dm_rdata` in 64: acknowledge; read data valid with the ack.
- `wb_valid` out 1: one-cycle pulse per retired instruction.
- `wb_alu_result` out 64, `wb_load_data` out 64, `wb_mem_to_reg` out 1 (write-back mux select), `wb_rd` out 5, `wb_reg_write` out 1.
- `wb_exc_align` out 1: misaligned access flag, valid with `wb_valid`.

## Operation
- Accept = `ex_valid & mem_ready & ~flush`. With `flush` high, nothing is captured.
- FSM states: IDLE and WAIT.
- Non-memory op accepted in IDLE:
  - wb registers load directly and `wb_valid` pulses next cycle.
  - State stays IDLE.
- Memory op accepted in IDLE with an aligned address (`addr & (bytes-1) == 0`):
  - Go to WAIT and hold the request fields in internal registers.
  - `dm_req`=1 throughout WAIT; request outputs stay stable until `dm_ack`.
- WAIT:
  - On `dm_ack`, capture extended load data, pulse `wb_valid` next cycle, return to IDLE.
  - `flush` is ignored in WAIT.
- Misaligned memory op:
  - No memory request is issued.
  - `wb_valid`=1 and `wb_exc_align`=1 next cycle.
  - `wb_reg_write` is forced to 0.
- Both `ex_mem_read` and `ex_mem_write` set: treated as a store; `wb_load_data`=0.
- Request encoding:
  - `dm_addr` = {addr[63:3],3'b000}.
  - `dm_be` = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - `dm_wdata` = store data << (8*addr[2:0]).
- Load extraction: `dm_rdata` >> (8*addr[2:0]), truncated to the access size, then sign- or zero-extended to 64.
- For stores, `wb_reg_write` is passed through as presented.
- `dm_ack` in IDLE is ignored.

## Timing
- Reset: state IDLE; `mem_ready`=1; all other outputs are 0, including `dm_*` outputs and all wb fields.
- Latency:
  - Non-memory or misaligned op: 1 cycle from accept to `wb_valid`.
  - Memory op: `wb_valid` one cycle after the `dm_ack` cycle.
  - Minimum memory-op latency is 2 cycles, with ack in the first WAIT cycle.
- `mem_ready` is low from the cycle after accepting a memory op through the `dm_ack` cycle. The next accept is possible the cycle after the ack.
- wb outputs hold their values between pulses. `wb_valid` is never high two consecutive cycles for the same instruction.
- Reset mid-WAIT: immediate return to IDLE and `dm_req` drops asynchronously; a later stray ack is ignored.

## Structure
- Package `mem_pkg`:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
  - FSM state enum
  - byte-enable mask constants
  - `size_bytes` function
- Sub-module `load_extend`: combinational; inputs `rdata`, `offset`[2:0], size, signed; output 64-bit extended data.
- Top holds the FSM, request registers and wb registers.

## Test plan
- Non-memory op, alu_result=0x1234, rd=3, reg_write=1 -> next cycle `wb_valid`=1, `wb_alu_result`=0x1234, `wb_rd`=3, `mem_to_reg`=0.
- Signed byte load at 0x1005, ack after 3 WAIT cycles, rdata=0x0000_8000_0000_0000 -> `dm_be`=0x20, `mem_ready` low 3 cycles, `wb_load_data`=0xFFFF_FFFF_FFFF_FF80.
- Word store at 0x2004, data=0xDEADBEEF -> `dm_addr`=0x2000, `dm_be`=0xF0, `dm_wdata`=0xDEADBEEF_0000_0000, `dm_we`=1 until ack.
- Half load at 0x3001 -> no `dm_req`; next cycle `wb_exc_align`=1, `wb_reg_write`=0.
- `flush` with `ex_valid` in IDLE -> no `wb_valid`; `rst_n` low during WAIT -> `dm_req`=0 at once, IDLE, and an ack after reset is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states,
// byte-enable masks and size helpers.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [7:0] BE_B = 8'h01;
    localparam logic [7:0] BE_H = 8'h03;
    localparam logic [7:0] BE_W = 8'h0F;
    localparam logic [7:0] BE_D = 8'hFF;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 4'd1;
            SZ_H:    size_bytes = 4'd2;
            SZ_W:    size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = BE_B;
            SZ_H:    size_mask = BE_H;
            SZ_W:    size_mask = BE_W;
            default: size_mask = BE_D;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed lane from a 64-bit read beat and sign- or
// zero-extends it to the full register width.
module load_extend
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [63:0] data
);

    logic [63:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            SZ_B:    data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
            SZ_H:    data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_W:    data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues aligned loads/stores over a req/ack
// data-memory port and registers the write-back result set.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        mem_ready,
    input  logic        flush,
    input  logic [63:0] ex_alu_result,
    input  logic [63:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [7:0]  dm_be,
    output logic [63:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [63:0] dm_rdata,
    output logic        wb_valid,
    output logic [63:0] wb_alu_result,
    output logic [63:0] wb_load_data,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_exc_align
);

    state_e      state_q, state_d;

    logic [63:0] addr_q, wdata_q;
    logic [7:0]  be_q;
    logic [1:0]  size_q;
    logic        we_q, load_q, signed_q, reg_write_q, mem_to_reg_q;
    logic [4:0]  rd_q;

    logic        wb_valid_q, wb_mem_to_reg_q, wb_reg_write_q, wb_exc_align_q;
    logic [63:0] wb_alu_result_q, wb_load_data_q;
    logic [4:0]  wb_rd_q;

    logic        accept, is_mem, aligned, start_req, ack_done;
    logic [3:0]  nbytes;
    logic [2:0]  align_mask;
    logic [63:0] ext_data;

    assign accept     = ex_valid & mem_ready & ~flush;
    assign is_mem     = ex_mem_read | ex_mem_write;
    assign nbytes     = size_bytes(ex_size);
    assign align_mask = 3'(nbytes - 4'd1);
    assign aligned    = (ex_alu_result[2:0] & align_mask) == 3'b000;
    assign start_req  = accept & is_mem & aligned;
    assign ack_done   = (state_q == ST_WAIT) & dm_ack;

    assign mem_ready = (state_q == ST_IDLE);
    assign dm_req    = (state_q == ST_WAIT);

    // Request fields are gated by dm_req so an async reset clears the port at once.
    assign dm_we    = dm_req & we_q;
    assign dm_addr  = dm_req ? {addr_q[63:3], 3'b000} : 64'd0;
    assign dm_be    = dm_req ? be_q : 8'd0;
    assign dm_wdata = dm_req ? wdata_q : 64'd0;

    load_extend u_load_extend (
        .rdata    (dm_rdata),
        .offset   (addr_q[2:0]),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (ext_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_req) state_d = ST_WAIT;
            ST_WAIT: if (dm_ack)    state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            load_q       <= 1'b0;
            signed_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q <= state_d;
            if (start_req) begin
                addr_q       <= ex_alu_result;
                wdata_q      <= ex_store_data << {ex_alu_result[2:0], 3'b000};
                be_q         <= size_mask(ex_size) << ex_alu_result[2:0];
                size_q       <= ex_size;
                we_q         <= ex_mem_write;
                load_q       <= ex_mem_read & ~ex_mem_write;
                signed_q     <= ex_signed;
                reg_write_q  <= ex_reg_write;
                mem_to_reg_q <= ex_mem_to_reg;
                rd_q         <= ex_rd;
            end
        end
    end

    // Retire either on the memory ack or directly for non-memory/misaligned ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q      <= 1'b0;
            wb_alu_result_q <= '0;
            wb_load_data_q  <= '0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_exc_align_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            if (ack_done) begin
                wb_valid_q      <= 1'b1;
                wb_alu_result_q <= addr_q;
                wb_load_data_q  <= load_q ? ext_data : 64'd0;
                wb_mem_to_reg_q <= mem_to_reg_q;
                wb_rd_q         <= rd_q;
                wb_reg_write_q  <= reg_write_q;
                wb_exc_align_q  <= 1'b0;
            end else if (accept && !start_req) begin
                wb_valid_q      <= 1'b1;
                wb_alu_result_q <= ex_alu_result;
                wb_load_data_q  <= 64'd0;
                wb_mem_to_reg_q <= ex_mem_to_reg;
                wb_rd_q         <= ex_rd;
                wb_reg_write_q  <= ex_reg_write & ~is_mem;
                wb_exc_align_q  <= is_mem;
            end
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_load_data  = wb_load_data_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_exc_align  = wb_exc_align_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-level
// behavioural model of loads, stores and write-back.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_ready, flush;
    logic [63:0] ex_alu_result, ex_store_data;
    logic        ex_mem_read, ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_to_reg;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr;
    logic [7:0]  dm_be;
    logic [63:0] dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        wb_valid;
    logic [63:0] wb_alu_result, wb_load_data;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, wb_exc_align;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .mem_ready     (mem_ready),
        .flush         (flush),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_size       (ex_size),
        .ex_signed     (ex_signed),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_be         (dm_be),
        .dm_wdata      (dm_wdata),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_alu_result (wb_alu_result),
        .wb_load_data  (wb_load_data),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_exc_align  (wb_exc_align)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        flush         = 1'b0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_size       = 2'b00;
        ex_signed     = 1'b0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
        dm_ack        = 1'b0;
        dm_rdata      = '0;
    endtask

    // Presents one instruction, plays the memory side, and checks the result.
    task automatic run_op(input logic [63:0] addr, input logic [1:0] sz, input logic sgn,
                          input logic rd_en, input logic wr_en, input logic [63:0] sdata,
                          input logic [63:0] rdata, input logic [4:0] rd, input logic rw,
                          input logic m2r, input int delay, input string tag);
        int          nb, off, be_i;
        logic        is_mem, aligned, exp_rw;
        logic [7:0]  exp_be;
        logic [63:0] exp_wd, exp_ld, mask;
        nb      = 1 << sz;
        off     = int'(addr % 64'd8);
        is_mem  = rd_en | wr_en;
        aligned = (addr % 64'(nb)) == 64'd0;
        be_i    = ((1 << nb) - 1) << off;
        exp_be  = be_i[7:0];
        exp_wd  = sdata << (8 * off);
        mask    = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        exp_ld  = (rdata >> (8 * off)) & mask;
        if (sgn && nb < 8 && exp_ld[8 * nb - 1]) exp_ld = exp_ld | ~mask;
        if (!rd_en || wr_en) exp_ld = 64'd0;
        exp_rw  = (is_mem && !aligned) ? 1'b0 : rw;

        ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = sdata;
        ex_mem_read = rd_en; ex_mem_write = wr_en; ex_size = sz; ex_signed = sgn;
        ex_rd = rd; ex_reg_write = rw; ex_mem_to_reg = m2r;
        step();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_alu_result = {$urandom, $urandom};

        if (is_mem && aligned) begin
            for (int k = 1; k <= delay; k++) begin
                n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL %s dm_req cyc%0d: got %b want 1", tag, k, dm_req); end
                n_cmp++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL %s mem_ready cyc%0d: got %b want 0", tag, k, mem_ready); end
                n_cmp++; if (dm_addr !== (addr & ~64'h7)) begin n_err++; $display("FAIL %s dm_addr: got %h want %h", tag, dm_addr, addr & ~64'h7); end
                n_cmp++; if (dm_be !== exp_be) begin n_err++; $display("FAIL %s dm_be: got %h want %h", tag, dm_be, exp_be); end
                n_cmp++; if (dm_we !== wr_en) begin n_err++; $display("FAIL %s dm_we: got %b want %b", tag, dm_we, wr_en); end
                if (wr_en) begin
                    n_cmp++; if (dm_wdata !== exp_wd) begin n_err++; $display("FAIL %s dm_wdata: got %h want %h", tag, dm_wdata, exp_wd); end
                end
                n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL %s wb_valid_wait: got %b want 0", tag, wb_valid); end
                flush = 1'($urandom_range(0, 1));
                if (k == delay) begin dm_ack = 1'b1; dm_rdata = rdata; end
                else dm_rdata = {$urandom, $urandom};
                step();
                dm_ack = 1'b0; flush = 1'b0;
            end
        end else if (is_mem) begin
            n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL %s dm_req_misaligned: got %b want 0", tag, dm_req); end
        end

        n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL %s wb_valid: got %b want 1", tag, wb_valid); end
        n_cmp++; if (wb_alu_result !== addr) begin n_err++; $display("FAIL %s wb_alu_result: got %h want %h", tag, wb_alu_result, addr); end
        n_cmp++; if (wb_rd !== rd) begin n_err++; $display("FAIL %s wb_rd: got %0d want %0d", tag, wb_rd, rd); end
        n_cmp++; if (wb_mem_to_reg !== m2r) begin n_err++; $display("FAIL %s wb_mem_to_reg: got %b want %b", tag, wb_mem_to_reg, m2r); end
        n_cmp++; if (wb_reg_write !== exp_rw) begin n_err++; $display("FAIL %s wb_reg_write: got %b want %b", tag, wb_reg_write, exp_rw); end
        n_cmp++; if (wb_exc_align !== (is_mem && !aligned)) begin n_err++; $display("FAIL %s wb_exc_align: got %b want %b", tag, wb_exc_align, is_mem && !aligned); end
        if (is_mem && aligned) begin
            n_cmp++; if (wb_load_data !== exp_ld) begin n_err++; $display("FAIL %s wb_load_data: got %h want %h", tag, wb_load_data, exp_ld); end
        end
        n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL %s mem_ready_after: got %b want 1", tag, mem_ready); end
        n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL %s dm_req_after: got %b want 0", tag, dm_req); end
    endtask

    task automatic idle_hold(input logic [63:0] last_alu, input string tag);
        dm_ack = 1'($urandom_range(0, 1));
        dm_rdata = {$urandom, $urandom};
        step();
        dm_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL %s idle_wb_valid: got %b want 0", tag, wb_valid); end
        n_cmp++; if (wb_alu_result !== last_alu) begin n_err++; $display("FAIL %s wb_hold: got %h want %h", tag, wb_alu_result, last_alu); end
        n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL %s idle_dm_req: got %b want 0", tag, dm_req); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL reset_mem_ready: got %b want 1", mem_ready); end
        n_cmp++; if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata} !== '0) begin n_err++; $display("FAIL reset_dm: got %b/%b/%h/%h/%h want all 0", dm_req, dm_we, dm_be, dm_addr, dm_wdata); end
        n_cmp++; if ({wb_valid, wb_alu_result, wb_load_data, wb_mem_to_reg, wb_rd, wb_reg_write, wb_exc_align} !== '0) begin
            n_err++; $display("FAIL reset_wb: got v%b alu%h ld%h m2r%b rd%0d rw%b exc%b want all 0", wb_valid, wb_alu_result, wb_load_data, wb_mem_to_reg, wb_rd, wb_reg_write, wb_exc_align);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_nonmem();
        run_op(64'h1234, 2'b00, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd3, 1'b1, 1'b0, 0, "nonmem_fixed");
        idle_hold(64'h1234, "nonmem_fixed");
        run_op({$urandom, $urandom}, 2'b11, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd17, 1'b1, 1'b0, 0, "nonmem_b2b_a");
        run_op(64'hFFFF_0000_1111_2222, 2'b01, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 5'd31, 1'b0, 1'b1, 0, "nonmem_b2b_b");
        idle_hold(64'hFFFF_0000_1111_2222, "nonmem_b2b");
    endtask

    task automatic test_fixed_mem();
        run_op(64'h1005, 2'b00, 1'b1, 1'b1, 1'b0, 64'd0, 64'h0000_8000_0000_0000, 5'd7, 1'b1, 1'b1, 3, "ldb_signed");
        run_op(64'h2004, 2'b10, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF, 64'd0, 5'd0, 1'b0, 1'b0, 2, "stw");
        run_op(64'h3001, 2'b01, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 5'd9, 1'b1, 1'b1, 0, "ldh_misaligned");
        run_op(64'h4008, 2'b11, 1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1'b1, 1'b0, 1, "ld_st_both");
        run_op(64'h5006, 2'b01, 1'b0, 1'b1, 1'b0, 64'd0, 64'hABCD_0000_0000_0000, 5'd2, 1'b1, 1'b1, 1, "ldh_unsigned");
        idle_hold(64'h5006, "fixed_mem");
    endtask

    task automatic test_flush();
        ex_valid = 1'b1; flush = 1'b1; ex_alu_result = 64'h7777;
        ex_mem_read = 1'b0; ex_reg_write = 1'b1;
        step();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_nonmem wb_valid: got %b want 0", wb_valid); end
        ex_mem_read = 1'b1; ex_size = 2'b11; ex_alu_result = 64'h8000;
        step();
        n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL flush_mem dm_req: got %b want 0", dm_req); end
        n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL flush_mem mem_ready: got %b want 1", mem_ready); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_mem wb_valid: got %b want 0", wb_valid); end
        idle_inputs();
    endtask

    task automatic test_reset_wait();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_size = 2'b11; ex_alu_result = 64'h40; ex_reg_write = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL rstwait dm_req_before: got %b want 1", dm_req); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL rstwait dm_req_async: got %b want 0", dm_req); end
        n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rstwait mem_ready: got %b want 1", mem_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        dm_ack = 1'b1; dm_rdata = 64'h1122_3344_5566_7788;
        step();
        dm_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rstwait stray_ack wb_valid: got %b want 0", wb_valid); end
        n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL rstwait stray_ack dm_req: got %b want 0", dm_req); end
        n_cmp++; if (wb_load_data !== 64'd0) begin n_err++; $display("FAIL rstwait wb_load_data: got %h want 0", wb_load_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a;
            logic [1:0]  sz;
            int          kind;
            sz   = 2'($urandom_range(0, 3));
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            kind = $urandom_range(0, 3);
            run_op(a, sz, 1'($urandom_range(0, 1)), kind == 1 || kind == 3, kind == 2 || kind == 3,
                   {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 4), "random");
            if ($urandom_range(0, 1) == 1) idle_hold(a, "random");
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_fixed_mem();
        test_flush();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
